// File: rtl/m_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m_spi_arbiter
// Purpose  : Round-robin arbiter sharing one SPI-master register port between
//            NREQ sequencer clients. A granted client owns the port for a whole
//            transaction until it drops req. A watchdog reclaims the port from
//            an owner that holds req without issuing strobes, and blocks that
//            client until it drops req.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   I_CLK, I_RESETN       clock (posedge), asynchronous active-low reset
//   req[NREQ]             per-client level request for port ownership
//   gnt[NREQ]             registered one-hot grant
//   owner[3]              index of current or last owner
//   busy                  high while in GRANT or RELEASE
//   timeout_err           one-cycle pulse on a watchdog release
//   c_tx_en/c_waddr/c_wdata/c_rx_en/c_raddr   per-client register strobes
//   c_rdata[DW]           read data broadcast to all clients (combinational)
//   I_TX_EN/I_WADDR/I_WDATA/I_RX_EN/I_RADDR   registered port to SPI master
//   O_RDATA[DW]           read data from SPI master
// ============================================================================
module m_spi_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                 I_CLK,
  input  logic                 I_RESETN,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic [NREQ-1:0]      c_tx_en,
  input  logic [3*NREQ-1:0]    c_waddr,
  input  logic [DW*NREQ-1:0]   c_wdata,
  input  logic [NREQ-1:0]      c_rx_en,
  input  logic [3*NREQ-1:0]    c_raddr,
  output logic [DW-1:0]        c_rdata,
  output logic                 I_TX_EN,
  output logic [2:0]           I_WADDR,
  output logic [DW-1:0]        I_WDATA,
  output logic                 I_RX_EN,
  output logic [2:0]           I_RADDR,
  input  logic [DW-1:0]        O_RDATA
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]      r_state, w_state_nxt;
  logic [2:0]      r_owner, w_owner_nxt;
  logic [2:0]      r_ptr, w_ptr_nxt;
  logic [2:0]      w_sel;
  logic            w_any;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_blocked, w_blocked_nxt;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_owner_hot;
  logic            r_terr;
  logic            w_rel_timeout;
  logic            w_wd_expire;

  logic            w_own_req, w_own_tx, w_own_rx, w_own_strobe;
  logic [2:0]      w_own_waddr, w_own_raddr;
  logic [DW-1:0]   w_own_wdata;

  logic            r_tx_en, r_rx_en;
  logic [2:0]      r_waddr, r_raddr;
  logic [DW-1:0]   r_wdata;

  // --------------------------------------------------------------------------
  // Current-owner multiplexer (constant indices only; owner is always < NREQ)
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_hot = '0;
    w_own_req   = 1'b0;
    w_own_tx    = 1'b0;
    w_own_rx    = 1'b0;
    w_own_waddr = '0;
    w_own_raddr = '0;
    w_own_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_owner == 3'(k)) begin
        w_owner_hot[k] = 1'b1;
        w_own_req      = req[k];
        w_own_tx       = c_tx_en[k];
        w_own_rx       = c_rx_en[k];
        w_own_waddr    = c_waddr[3*k +: 3];
        w_own_raddr    = c_raddr[3*k +: 3];
        w_own_wdata    = c_wdata[DW*k +: DW];
      end
    end
  end

  assign w_own_strobe = w_own_tx | w_own_rx;

  // --------------------------------------------------------------------------
  // Round-robin selection: first eligible index at or above the pointer,
  // wrapping modulo NREQ. Outer loop is the search offset, so the lowest
  // offset wins.
  // --------------------------------------------------------------------------
  assign w_elig = req & ~r_blocked;

  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_any && w_elig[k] && (k == ((int'(r_ptr) + i) % NREQ))) begin
          w_any = 1'b1;
          w_sel = 3'(k);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog: consecutive strobe-free GRANT cycles. Expiry is flagged on the
  // TIMEOUT-th idle cycle; the FSM only treats it as a timeout if req is held.
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [WDW-1:0] r_wd;
      logic           w_wd_last;

      assign w_wd_last = (r_wd == WDW'(TIMEOUT - 1));

      always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
          r_wd <= '0;
        end else if ((r_state != S_GRANT) || w_own_strobe) begin
          r_wd <= '0;
        end else if (!w_wd_last) begin
          r_wd <= r_wd + WDW'(1);
        end
      end

      assign w_wd_expire = (r_state == S_GRANT) && !w_own_strobe && w_wd_last;
    end else begin : g_no_wd
      assign w_wd_expire = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_blocked <= '0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_blocked <= w_blocked_nxt;
      r_terr    <= w_rel_timeout;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_GRANT;
      S_GRANT:   if (!w_own_req || w_wd_expire) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / bookkeeping logic
  // --------------------------------------------------------------------------
  always_comb begin
    // A falling req wins over a simultaneous watchdog expiry.
    w_rel_timeout = (r_state == S_GRANT) && w_own_req && w_wd_expire;
    w_owner_nxt   = ((r_state == S_IDLE) && w_any) ? w_sel : r_owner;

    w_gnt_nxt = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_gnt_nxt[k] = (w_state_nxt == S_GRANT) && (w_owner_nxt == 3'(k));
    end

    w_ptr_nxt = r_ptr;
    if ((r_state == S_GRANT) && (w_state_nxt == S_RELEASE)) begin
      w_ptr_nxt = (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;
    end

    // A block is dropped on any cycle the client's req is low.
    w_blocked_nxt = (r_blocked | (w_rel_timeout ? w_owner_hot : '0)) & req;
  end

  assign busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Forwarding registers. Only GRANT forwards the owner's strobes; every other
  // state loads zero strobes. Addresses/data hold when their strobe is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      r_tx_en <= 1'b0;
      r_rx_en <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_raddr <= '0;
    end else if (r_state == S_GRANT) begin
      r_tx_en <= w_own_tx;
      r_rx_en <= w_own_rx;
      if (w_own_tx) begin
        r_waddr <= w_own_waddr;
        r_wdata <= w_own_wdata;
      end
      if (w_own_rx) begin
        r_raddr <= w_own_raddr;
      end
    end else begin
      r_tx_en <= 1'b0;
      r_rx_en <= 1'b0;
    end
  end

  assign gnt         = r_gnt;
  assign owner       = r_owner;
  assign timeout_err = r_terr;
  assign I_TX_EN     = r_tx_en;
  assign I_WADDR     = r_waddr;
  assign I_WDATA     = r_wdata;
  assign I_RX_EN     = r_rx_en;
  assign I_RADDR     = r_raddr;
  assign c_rdata     = O_RDATA;

endmodule
`default_nettype wire

// File: tb/tb_m_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_spi_arbiter
// Purpose  : Self-checking bench for m_spi_arbiter (NREQ=2, DW=8, TIMEOUT=16).
//            A transaction-level model predicts every output each cycle;
//            directed scenarios add hand-derived literal expectations, then a
//            randomized phase exercises arbitration, watchdog and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_spi_arbiter;

  localparam int NREQ    = 2;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [2:0]          owner;
  logic                busy;
  logic                timeout_err;
  logic [NREQ-1:0]     c_tx_en;
  logic [3*NREQ-1:0]   c_waddr;
  logic [DW*NREQ-1:0]  c_wdata;
  logic [NREQ-1:0]     c_rx_en;
  logic [3*NREQ-1:0]   c_raddr;
  logic [DW-1:0]       c_rdata;
  logic                I_TX_EN;
  logic [2:0]          I_WADDR;
  logic [DW-1:0]       I_WDATA;
  logic                I_RX_EN;
  logic [2:0]          I_RADDR;
  logic [DW-1:0]       O_RDATA;

  m_spi_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .I_CLK(clk), .I_RESETN(rst_n),
    .req(req), .gnt(gnt), .owner(owner), .busy(busy), .timeout_err(timeout_err),
    .c_tx_en(c_tx_en), .c_waddr(c_waddr), .c_wdata(c_wdata),
    .c_rx_en(c_rx_en), .c_raddr(c_raddr), .c_rdata(c_rdata),
    .I_TX_EN(I_TX_EN), .I_WADDR(I_WADDR), .I_WDATA(I_WDATA),
    .I_RX_EN(I_RX_EN), .I_RADDR(I_RADDR), .O_RDATA(O_RDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model. m_phase: 0 = port free, 1 = owned, 2 = cool-down
  // cycle after a release. m_idle counts consecutive strobe-free owned cycles.
  // The e_* values are what the outputs must show after the next clock edge.
  // --------------------------------------------------------------------------
  int              m_phase, m_own, m_ptr, m_idle;
  bit [NREQ-1:0]   m_blk;
  logic [NREQ-1:0] e_gnt;
  logic [2:0]      e_owner, e_wa, e_ra;
  logic            e_busy, e_terr, e_tx, e_rx;
  logic [DW-1:0]   e_wd;

  task automatic model_reset();
    m_phase = 0; m_own = 0; m_ptr = 0; m_idle = 0; m_blk = '0;
    e_gnt = '0; e_owner = '0; e_busy = 1'b0; e_terr = 1'b0;
    e_tx = 1'b0; e_rx = 1'b0; e_wa = '0; e_ra = '0; e_wd = '0;
  endtask

  task automatic model_step();
    bit found;
    int k;
    e_terr = 1'b0;
    e_tx   = 1'b0;
    e_rx   = 1'b0;
    found  = 1'b0;
    if (m_phase == 0) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (!found && req[k] && !m_blk[k]) begin
          found = 1'b1;
          m_own = k;
        end
      end
      if (found) begin
        m_phase = 1;
        m_idle  = 0;
      end
    end else if (m_phase == 1) begin
      e_tx = c_tx_en[m_own];
      e_rx = c_rx_en[m_own];
      if (e_tx) begin
        e_wa = c_waddr[3*m_own +: 3];
        e_wd = c_wdata[DW*m_own +: DW];
      end
      if (e_rx) e_ra = c_raddr[3*m_own +: 3];
      if (e_tx || e_rx) m_idle = 0;
      else m_idle++;
      if (!req[m_own]) begin
        m_phase = 2;
        m_ptr   = (m_own + 1) % NREQ;
      end else if (m_idle >= TIMEOUT) begin
        m_phase      = 2;
        m_ptr        = (m_own + 1) % NREQ;
        e_terr       = 1'b1;
        m_blk[m_own] = 1'b1;
      end
    end else begin
      m_phase = 0;
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!req[j]) m_blk[j] = 1'b0;
    end
    e_gnt = '0;
    if (m_phase == 1) e_gnt[m_own] = 1'b1;
    e_busy  = (m_phase != 0);
    e_owner = 3'(m_own);
  endtask

  // Compare process: inputs change only at posedge+2, so at the negedge the
  // DUT outputs reflect the last edge and the inputs are those for the next.
  always @(negedge clk) begin
    n_vec++;
    if (!rst_n) model_reset();
    chk("gnt",         gnt,         e_gnt);
    chk("owner",       owner,       e_owner);
    chk("busy",        busy,        e_busy);
    chk("timeout_err", timeout_err, e_terr);
    chk("I_TX_EN",     I_TX_EN,     e_tx);
    chk("I_RX_EN",     I_RX_EN,     e_rx);
    chk("I_WADDR",     I_WADDR,     e_wa);
    chk("I_WDATA",     I_WDATA,     e_wd);
    chk("I_RADDR",     I_RADDR,     e_ra);
    chk("c_rdata",     c_rdata,     O_RDATA);
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  int rr_exp[4] = '{1, 0, 1, 0};
  int n, w, cur, p, q;

  initial begin
    model_reset();
    rst_n = 1'b0; req = '0; c_tx_en = '0; c_rx_en = '0;
    c_waddr = '0; c_wdata = '0; c_raddr = '0; O_RDATA = '0;
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx", I_TX_EN, 0);
    rst_n = 1'b1;
    tick();

    // ---- single client write --------------------------------------------
    req = 2'b01;
    tick();
    chk("single_gnt", gnt, 2'b01);
    chk("single_busy", busy, 1);
    tick();
    c_tx_en[0] = 1'b1; c_waddr[2:0] = 3'd4; c_wdata[7:0] = 8'h01;
    tick();
    chk("single_tx", I_TX_EN, 1);
    chk("single_waddr", I_WADDR, 4);
    chk("single_wdata", I_WDATA, 8'h01);
    c_tx_en = '0; req = '0;
    tick();
    chk("single_rel_busy", busy, 1);
    chk("single_rel_gnt", gnt, 0);
    tick();
    chk("single_idle_busy", busy, 0);

    // ---- read path --------------------------------------------------------
    req = 2'b01;
    tick();
    c_rx_en[0] = 1'b1; c_raddr[2:0] = 3'd2;
    tick();
    chk("rd_rx", I_RX_EN, 1);
    chk("rd_raddr", I_RADDR, 2);
    c_rx_en = '0; O_RDATA = 8'h30;
    #1;
    chk("rd_rdata", c_rdata, 8'h30);
    tick();
    chk("rd_rx_width", I_RX_EN, 0);
    req = '0;
    repeat (3) tick();

    // ---- round robin (pointer is 1 after client 0's releases) -------------
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (gnt == '0 && w < 10) begin tick(); w++; end
      chk("rr_granted", (gnt != '0), 1);
      chk("rr_owner", owner, rr_exp[g]);
      cur = rr_exp[g];
      repeat (5) begin
        c_tx_en = '0; c_tx_en[1-cur] = 1'b1;
        tick();
        chk("rr_nonowner_tx", I_TX_EN, 0);
      end
      c_tx_en = '0; req[cur] = 1'b0;
      tick();
      req[cur] = 1'b1;
    end
    req = '0;
    repeat (4) tick();

    // ---- watchdog ---------------------------------------------------------
    req = 2'b10;
    tick();
    chk("wd_gnt1", gnt, 2'b10);
    req = 2'b11;
    n = 0;
    while (n < 40) begin
      tick(); n++;
      if (timeout_err) break;
    end
    chk("wd_idle_cycles", n, 16);
    chk("wd_gnt_off", gnt, 0);
    tick();
    chk("wd_pulse_once", timeout_err, 0);
    tick();
    chk("wd_client0_next", gnt, 2'b01);
    repeat (2) tick();
    req = 2'b10;
    repeat (2) tick();
    repeat (4) begin
      tick();
      chk("wd_blocked", gnt, 0);
    end
    req = '0;
    tick();
    req = 2'b10;
    tick();
    chk("wd_regrant", gnt, 2'b10);
    req = '0;
    repeat (3) tick();

    // ---- req falls on the watchdog's terminal cycle -----------------------
    req = 2'b01;
    tick();
    chk("sim_gnt", gnt, 2'b01);
    repeat (15) tick();
    req = '0;
    tick();
    chk("sim_no_terr", timeout_err, 0);
    chk("sim_gnt_off", gnt, 0);
    chk("sim_busy", busy, 1);
    req = 2'b01;
    repeat (2) tick();
    chk("sim_not_blocked", gnt, 2'b01);
    req = '0;
    repeat (3) tick();

    // ---- reset in the middle of a grant ------------------------------------
    req = 2'b01;
    tick();
    c_tx_en = 2'b01;
    tick();
    chk("mr_tx", I_TX_EN, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_gnt", gnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_tx_off", I_TX_EN, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_no_strobe", I_TX_EN, 0);
    chk("mr_regrant", gnt, 2'b01);
    tick();
    chk("mr_new_strobe", I_TX_EN, 1);
    c_tx_en = '0; req = '0;
    repeat (3) tick();

    // ---- randomized traffic -------------------------------------------------
    for (int c = 0; c < 3000; c++) begin
      p = (((c / 400) % 2) != 0) ? 40 : 3;
      q = (p == 40) ? 40 : 12;
      rst_n = ($urandom_range(0, 1499) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (req[k]) begin
          if ($urandom_range(0, q - 1) == 0) req[k] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[k] = 1'b1;
        end
        c_tx_en[k] = ($urandom_range(0, p - 1) == 0);
        c_rx_en[k] = ($urandom_range(0, p - 1) == 0);
      end
      c_waddr = 6'($urandom);
      c_raddr = 6'($urandom);
      c_wdata = 16'($urandom);
      O_RDATA = 8'($urandom);
      tick();
    end

    rst_n = 1'b1; req = '0; c_tx_en = '0; c_rx_en = '0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
